// File: rtl/vga_timing_gen.sv
// Video timing generator: walks the raster and emits pixel coordinates, display enable,
// line/frame start pulses, and hsync/vsync/de delayed by SYNC_DELAY updates.
// Latency: one clk from pix_en_i to x_o/y_o, plus SYNC_DELAY updates for hsync_o/vsync_o/de_o.
// Backpressure: none; pix_en_i low freezes counters and level outputs, and pulses drop to 0.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   pix_en_i          one raster step per cycle where high
//   x_o, y_o          raw raster counters of the current pixel (run past the active area)
//   display_enable_o  current pixel is visible
//   line_start_o      1-clk pulse when x_o moved to 0
//   frame_start_o     1-clk pulse when (x_o, y_o) moved to (0, 0)
//   hsync_o, vsync_o  delayed syncs at HSYNC_POL / VSYNC_POL asserted level
//   de_o              delayed display enable for the physical port
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int SYNC_DELAY = 1,
  parameter int COORD_W    = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_en_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               display_enable_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // Sync bundle order: {hsync, vsync, de}; idle is both syncs deasserted, de low.
  localparam logic [2:0] SYNC_IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

  logic [COORD_W-1:0] r_h_cnt, r_v_cnt;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_de, r_ls, r_fs, r_hs, r_vs;

  logic w_h_last, w_v_last, w_de, w_hs_act, w_vs_act, w_hs, w_vs;
  logic [2:0] w_sync_now, w_sync_dly;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign w_vs_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);
  assign w_hs     = w_hs_act ? HSYNC_POL : ~HSYNC_POL;
  assign w_vs     = w_vs_act ? VSYNC_POL : ~VSYNC_POL;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_hs    <= ~HSYNC_POL;
      r_vs    <= ~VSYNC_POL;
    end else if (pix_en_i) begin
      // Outputs describe the pixel the counters point at before they advance.
      r_x  <= r_h_cnt;
      r_y  <= r_v_cnt;
      r_de <= w_de;
      r_ls <= (r_h_cnt == '0);
      r_fs <= (r_h_cnt == '0) && (r_v_cnt == '0);
      r_hs <= w_hs;
      r_vs <= w_vs;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + COORD_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + COORD_W'(1);
      end
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign w_sync_now = {r_hs, r_vs, r_de};

  // Stage 0 captures the bundle as it stood before this update, so after
  // update k stage N-1 holds the values of pixel k-N.
  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign w_sync_dly = w_sync_now;
    end else begin : g_dly
      logic [2:0] r_dly [SYNC_DELAY];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < SYNC_DELAY; i++) r_dly[i] <= SYNC_IDLE;
        end else if (pix_en_i) begin
          r_dly[0] <= w_sync_now;
          for (int i = 1; i < SYNC_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_sync_dly = r_dly[SYNC_DELAY-1];
    end
  endgenerate

  assign x_o              = r_x;
  assign y_o              = r_y;
  assign display_enable_o = r_de;
  assign line_start_o     = r_ls;
  assign frame_start_o    = r_fs;
  assign hsync_o          = w_sync_dly[2];
  assign vsync_o          = w_sync_dly[1];
  assign de_o             = w_sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic pix_en_i;

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Full-size raster, no sync delay.
  logic [9:0] b_x, b_y;
  logic b_de, b_ls, b_fs, b_hs, b_vs, b_deo;
  // Small raster (15 x 8): active 8x4, hsync h=10..12, vsync v=5..6.
  logic [3:0] s0_x, s0_y, s2_x, s2_y;
  logic s0_de, s0_ls, s0_fs, s0_hs, s0_vs, s0_deo;
  logic s2_de, s2_ls, s2_fs, s2_hs, s2_vs, s2_deo;

  vga_timing_gen #(.SYNC_DELAY(0)) u_big (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_en_i(pix_en_i),
    .x_o(b_x), .y_o(b_y), .display_enable_o(b_de),
    .line_start_o(b_ls), .frame_start_o(b_fs),
    .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_deo)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SYNC_DELAY(0), .COORD_W(4)
  ) u_sm0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_en_i(pix_en_i),
    .x_o(s0_x), .y_o(s0_y), .display_enable_o(s0_de),
    .line_start_o(s0_ls), .frame_start_o(s0_fs),
    .hsync_o(s0_hs), .vsync_o(s0_vs), .de_o(s0_deo)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .SYNC_DELAY(2), .COORD_W(4)
  ) u_sm2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .pix_en_i(pix_en_i),
    .x_o(s2_x), .y_o(s2_y), .display_enable_o(s2_de),
    .line_start_o(s2_ls), .frame_start_o(s2_fs),
    .hsync_o(s2_hs), .vsync_o(s2_vs), .de_o(s2_deo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected small-raster values for update index n (negative = before first update).
  function automatic int eh(int n); return n % 15; endfunction
  function automatic int ev(int n); return (n / 15) % 8; endfunction
  function automatic logic e_de(int n);
    if (n < 0) return 1'b0;
    return (eh(n) < 8) && (ev(n) < 4);
  endfunction
  function automatic logic e_hs_act(int n);
    if (n < 0) return 1'b0;
    return (eh(n) >= 10) && (eh(n) < 13);
  endfunction
  function automatic logic e_vs_act(int n);
    if (n < 0) return 1'b0;
    return (ev(n) >= 5) && (ev(n) < 7);
  endfunction

  task automatic chk_reset(input string ph);
    chk({ph, " b_x"}, b_x, 0);
    chk({ph, " b_y"}, b_y, 0);
    chk({ph, " b_de"}, b_de, 0);
    chk({ph, " b_hs"}, b_hs, 1);
    chk({ph, " s0_x"}, s0_x, 0);
    chk({ph, " s0_y"}, s0_y, 0);
    chk({ph, " s0_de"}, s0_de, 0);
    chk({ph, " s0_ls"}, s0_ls, 0);
    chk({ph, " s0_fs"}, s0_fs, 0);
    chk({ph, " s0_hs"}, s0_hs, 1);
    chk({ph, " s0_vs"}, s0_vs, 1);
    chk({ph, " s0_deo"}, s0_deo, 0);
    chk({ph, " s2_hs"}, s2_hs, 1);
    chk({ph, " s2_vs"}, s2_vs, 0);
    chk({ph, " s2_deo"}, s2_deo, 0);
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last;
    int fs_k [$];

    // Reset state, clock running.
    rst_ni   = 1'b0;
    pix_en_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset("rst");

    // Continuous pix_en: update n is observed 1 time unit after edge n.
    rst_ni   = 1'b1;
    pix_en_i = 1'b1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int n = 0; n <= 800; n++) begin
      @(posedge clk_i);
      #1;
      // Full-size raster directed points.
      if (n == 0) begin
        chk("u0 b_x", b_x, 0);
        chk("u0 b_y", b_y, 0);
        chk("u0 b_de", b_de, 1);
        chk("u0 b_ls", b_ls, 1);
        chk("u0 b_fs", b_fs, 1);
      end
      if (n == 639) chk("u639 b_de", b_de, 1);
      if (n == 640) begin
        chk("u640 b_de", b_de, 0);
        chk("u640 b_deo", b_deo, 0);
        chk("u640 b_x", b_x, 640);
      end
      if (n == 800) begin
        chk("u800 b_x", b_x, 0);
        chk("u800 b_y", b_y, 1);
        chk("u800 b_ls", b_ls, 1);
        chk("u800 b_fs", b_fs, 0);
      end
      if (n < 800 && b_hs == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = n;
        hs_last = n;
      end
      // Small raster, every update.
      chk($sformatf("c n=%0d s0_x", n), s0_x, eh(n));
      chk($sformatf("c n=%0d s0_y", n), s0_y, ev(n));
      chk($sformatf("c n=%0d s0_de", n), s0_de, e_de(n));
      chk($sformatf("c n=%0d s0_ls", n), s0_ls, eh(n) == 0);
      chk($sformatf("c n=%0d s0_fs", n), s0_fs, eh(n) == 0 && ev(n) == 0);
      chk($sformatf("c n=%0d s0_hs", n), s0_hs, !e_hs_act(n));
      chk($sformatf("c n=%0d s0_vs", n), s0_vs, !e_vs_act(n));
      chk($sformatf("c n=%0d s0_deo", n), s0_deo, e_de(n));
      chk($sformatf("c n=%0d s2_deo", n), s2_deo, e_de(n - 2));
      chk($sformatf("c n=%0d s2_hs", n), s2_hs, !e_hs_act(n - 2));
      chk($sformatf("c n=%0d s2_vs", n), s2_vs, e_vs_act(n - 2));
    end
    chk("b hsync low count", hs_cnt, 96);
    chk("b hsync first", hs_first, 656);
    chk("b hsync last", hs_last, 751);

    // Run to (5,3) on the small raster, then reset asynchronously between edges.
    #2 rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(posedge clk_i);
      #1;
    end
    chk("pre-rst s0_x", s0_x, 5);
    chk("pre-rst s0_y", s0_y, 3);
    chk("pre-rst b_x", b_x, 50);
    #2 rst_ni = 1'b0;
    pix_en_i = 1'b0;
    #1;
    chk_reset("async");
    #1 rst_ni = 1'b1;

    // pix_en on every second clk: update u = k/2 happens on even k.
    for (int k = 0; k < 500; k++) begin
      int u;
      pix_en_i = (k % 2 == 0);
      @(posedge clk_i);
      #1;
      u = k / 2;
      chk($sformatf("h k=%0d s0_x", k), s0_x, eh(u));
      chk($sformatf("h k=%0d s0_y", k), s0_y, ev(u));
      chk($sformatf("h k=%0d s0_de", k), s0_de, e_de(u));
      chk($sformatf("h k=%0d s0_ls", k), s0_ls, (k % 2 == 0) && eh(u) == 0);
      chk($sformatf("h k=%0d s0_fs", k), s0_fs, (k % 2 == 0) && eh(u) == 0 && ev(u) == 0);
      chk($sformatf("h k=%0d s2_deo", k), s2_deo, e_de(u - 2));
      if (s0_fs) fs_k.push_back(k);
    end
    chk("half fs count", fs_k.size(), 3);
    if (fs_k.size() == 3) begin
      chk("half fs first", fs_k[0], 0);
      chk("half fs period", fs_k[1] - fs_k[0], 240);
      chk("half fs period2", fs_k[2] - fs_k[1], 240);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
